if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-register PC fetch with a credit-controlled fetch pipeline and a FIFO fetch queue. It issues sequential or redirected PCs to the synchronous instruction SRAM and captures each returned word with its PC. It presents the oldest {pc, inst} pair to ID and decouples SRAM latency from ID back-pressure. Sits between the branch-resolution logic (br_bus) and ID, driving the inst_sram port.

---
 rtl/if_fetch_queue.sv | 139 +++++++++++++
 tb/tb_if_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: credit-limited SRAM fetch pipeline feeding a FIFO that presents {pc, inst} to ID.
// Optional same-cycle response bypass to ID when the queue is empty: define IF_FQ_BYPASS_EN.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int unsigned FQ_DEPTH = 4,
  parameter int unsigned PTR_W    = $clog2(FQ_DEPTH),
  parameter int unsigned STALL_W  = 2,
  parameter int unsigned BR_WD    = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [BR_WD-1:0]   br_bus,
  input  logic [31:0]        inst_sram_rdata,
  output logic [64:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = PTR_W + 2;

  logic             br_e;
  logic [31:0]      br_addr;

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      pc_mem_q   [FQ_DEPTH];
  logic [31:0]      inst_mem_q [FQ_DEPTH];

  logic [CRD_W-1:0] credit;
  logic             issue;
  logic             resp_vld;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Issue/push/pop decisions; a pop in this cycle does not free a credit for issue.
  always_comb begin
    credit   = CRD_W'(count_q) + CRD_W'(inflight_q);
    issue    = !rst && !br_e && !stall[0] && (credit < CRD_W'(FQ_DEPTH));
    resp_vld = inflight_q && !br_e;
    pop      = (count_q != '0) && !stall[1];
`ifdef IF_FQ_BYPASS_EN
    bypass   = (count_q == '0) && resp_vld && !stall[1];
`else
    bypass   = 1'b0;
`endif
    push     = resp_vld && !bypass;
  end

  // Next-state logic; a redirect flushes the queue and drops the returning word.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (br_e) begin
      pc_d    = br_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[tail_q]   <= inflight_pc_q;
      inst_mem_q[tail_q] <= inst_sram_rdata;
    end
  end

  // Credit scheme guarantees these never fire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(FQ_DEPTH));
      assert (!(push && !pop && (count_q == CNT_W'(FQ_DEPTH))));
    end
  end

  always_comb begin
    id_valid = !rst && ((count_q != '0) || bypass);
    id_pc    = bypass ? inflight_pc_q   : pc_mem_q[head_q];
    id_inst  = bypass ? inst_sram_rdata : inst_mem_q[head_q];
  end

  assign if_to_id_bus    = {id_valid, id_pc, id_inst};
  assign inst_sram_en    = issue;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency SRAM returning addr ^ 32'h5a5a_5a5a.
module tb_if_fetch_queue;

  localparam logic [31:0] BASE = 32'hbfc0_0000;
  localparam logic [31:0] KEY  = 32'h5a5a_5a5a;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall;
  logic [32:0] br_bus;
  logic [31:0] rdata;
  logic [64:0] bus;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_q = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (en) sram_q <= addr;
  assign rdata = sram_q ^ KEY;

  if_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .inst_sram_rdata (rdata),
    .if_to_id_bus    (bus),
    .inst_sram_en    (en),
    .inst_sram_wen   (wen),
    .inst_sram_addr  (addr),
    .inst_sram_wdata (wdata)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] ent(input logic [31:0] pc);
    return {1'b1, pc, pc ^ KEY};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    stall  = 2'b00;
    br_bus = 33'h0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_en",    en,      0);
    check("rst_valid", bus[64], 0);
    check("rst_addr",  addr,    BASE);
    check("rst_wen",   wen,     0);
    check("rst_wdata", wdata,   0);

    rst = 1'b0;
    #1;
    check("c0_en",    en,      1);
    check("c0_addr",  addr,    BASE);
    check("c0_valid", bus[64], 0);
    next_cycle;

`ifndef IF_FQ_BYPASS_EN
    #1;
    check("c1_addr",  addr,    BASE + 32'd4);
    check("c1_valid", bus[64], 0);
    next_cycle;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("stream", bus, ent(BASE + 32'(4 * k)));
      next_cycle;
    end

    // ID back-pressure: queue fills to 4 then issue stops
    stall = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("hold_head", bus, ent(BASE + 32'h18));
      check("hold_en",   en,  (i < 2) ? 1 : 0);
      check("hold_addr", addr, (i < 2) ? BASE + 32'h20 + 32'(4 * i) : BASE + 32'h28);
      next_cycle;
    end
    stall = 2'b00;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("drain", bus, ent(BASE + 32'h18 + 32'(4 * j)));
      check("drain_en", en, (j != 0) ? 1 : 0);
      if (j != 0) check("drain_addr", addr, BASE + 32'h24 + 32'(4 * j));
      next_cycle;
    end

    // Build 3 queued + 1 in flight, then redirect
    stall = 2'b10;
    #1;
    check("pre_br_bus",  bus,  ent(BASE + 32'h38));
    check("pre_br_addr", addr, BASE + 32'h44);
    next_cycle;
    br_bus = {1'b1, 32'h8000_0100};
    #1;
    check("br_en",  en,  0);
    check("br_bus", bus, ent(BASE + 32'h38));
    next_cycle;
    br_bus = 33'h0;
    stall  = 2'b00;
    #1;
    check("br1_valid", bus[64], 0);
    check("br1_en",    en,      1);
    check("br1_addr",  addr,    32'h8000_0100);
    next_cycle;
    #1;
    check("br2_valid", bus[64], 0);
    check("br2_addr",  addr,    32'h8000_0104);
    next_cycle;
    #1;
    check("br3_bus", bus, ent(32'h8000_0100));
    next_cycle;

    // Issue stall: queued entries still pop
    stall = 2'b01;
    #1;
    check("s0_bus",  bus,  ent(32'h8000_0104));
    check("s0_en",   en,   0);
    check("s0_addr", addr, 32'h8000_010c);
    next_cycle;
    #1;
    check("s1_bus", bus, ent(32'h8000_0108));
    check("s1_en",  en,  0);
    next_cycle;
    #1;
    check("s2_valid", bus[64], 0);
    check("s2_en",    en,      0);
    check("s2_addr",  addr,    32'h8000_010c);
    next_cycle;
    stall = 2'b00;
    #1;
    check("s3_en",   en,   1);
    check("s3_addr", addr, 32'h8000_010c);
    next_cycle;
    #1;
    check("s4_valid", bus[64], 0);
    check("s4_addr",  addr,    32'h8000_0110);
    next_cycle;
    #1;
    check("s5_bus", bus, ent(32'h8000_010c));
    next_cycle;

    // PC wrap
    br_bus = {1'b1, 32'hffff_fffc};
    #1;
    check("w0_en", en, 0);
    next_cycle;
    br_bus = 33'h0;
    #1;
    check("w1_addr",  addr,    32'hffff_fffc);
    check("w1_valid", bus[64], 0);
    next_cycle;
    #1;
    check("w2_addr", addr, 32'h0000_0000);
    next_cycle;
    #1;
    check("w3_bus", bus, ent(32'hffff_fffc));
    next_cycle;
    #1;
    check("w4_bus", bus, ent(32'h0000_0000));
    next_cycle;

    // Mid-operation reset
    rst = 1'b1;
    #1;
    check("mr_en",    en,      0);
    check("mr_valid", bus[64], 0);
    next_cycle;
    rst = 1'b0;
    #1;
    check("mr0_addr",  addr,    BASE);
    check("mr0_en",    en,      1);
    check("mr0_valid", bus[64], 0);
    next_cycle;
    #1;
    check("mr1_valid", bus[64], 0);
    next_cycle;
    #1;
    check("mr2_bus", bus, ent(BASE));
    next_cycle;
`else
    #1;
    check("byp1_bus", bus, ent(BASE));
    next_cycle;
    #1;
    check("byp2_bus", bus, ent(BASE + 32'd4));
    next_cycle;
    stall = 2'b10;
    #1;
    check("byp3_valid", bus[64], 0);
    next_cycle;
    stall = 2'b00;
    #1;
    check("byp4_bus", bus, ent(BASE + 32'd8));
    next_cycle;
    #1;
    check("byp5_bus", bus, ent(BASE + 32'd12));
    next_cycle;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
